// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register for the 16-bit core with load-use stall detection,
// taken-branch squash control and saturating stall/flush event counters.
module if_id_hazard_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [15:0]      PC_i,
  input  logic [15:0]      instr_i,
  input  logic             branch_taken_i,
  input  logic             EX_MemRead_i,
  input  logic [2:0]       EX_RT_reg_i,
  output logic [15:0]      PC_o,
  output logic [15:0]      instr_o,
  output logic             valid_o,
  output logic [2:0]       RS_reg_o,
  output logic [2:0]       RT_reg_o,
  output logic [2:0]       RD_reg_o,
  output logic             pc_write_o,
  output logic             Data_ID_EX_Flush,
  output logic             Branch_ID_EX_Flush,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RESET_BUBBLE, RUN, STALLED} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;
  logic        hz, squash, stall;
  logic        cnt_inc [2];

  assign PC_o     = pc_reg;
  assign instr_o  = instr_reg;
  assign valid_o  = valid_reg;
  assign RS_reg_o = instr_reg[12:10];
  assign RT_reg_o = instr_reg[9:7];
  assign RD_reg_o = instr_reg[6:4];

  // r0 is hard-wired zero, so a load targeting it never creates a dependency
  assign hz = valid_reg & EX_MemRead_i & (EX_RT_reg_i != 3'd0) &
              ((EX_RT_reg_i == instr_reg[12:10]) | (EX_RT_reg_i == instr_reg[9:7]));

  assign squash = branch_taken_i;
  assign stall  = hz & ~squash;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    instr_next         = instr_reg;
    valid_next         = valid_reg;
    pc_write_o         = 1'b1;
    Data_ID_EX_Flush   = 1'b0;
    Branch_ID_EX_Flush = branch_taken_i;

    case (state_reg)
      RESET_BUBBLE: state_next = RUN;
      RUN, STALLED: state_next = stall ? STALLED : RUN;
      default:      state_next = RUN;
    endcase

    if (squash) begin
      pc_next    = PC_i;
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end else if (stall) begin
      pc_write_o       = 1'b0;
      Data_ID_EX_Flush = 1'b1;
    end else begin
      pc_next    = PC_i;
      instr_next = instr_i;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_BUBBLE;
      pc_reg    <= 16'h0000;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  assign cnt_inc[0] = stall;
  assign cnt_inc[1] = squash;

  // Counter 0 tracks load-use stall cycles, counter 1 tracks branch squashes
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    if (gi == 0) begin : g_stall
      assign stall_cnt_o = cnt_reg;
    end else begin : g_flush
      assign flush_cnt_o = cnt_reg;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Randomized self-checking bench for if_id_hazard_stage against a behavioural
// model of the IF/ID register contents and the two event counts.
module tb_if_id_hazard_stage;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [15:0] NOP = 16'h0000;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   PC_i = '0, instr_i = '0;
  logic          branch_taken_i = 1'b0, EX_MemRead_i = 1'b0;
  logic [2:0]    EX_RT_reg_i = '0;
  logic [15:0]   PC_o, instr_o;
  logic          valid_o, pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush;
  logic [2:0]    RS_reg_o, RT_reg_o, RD_reg_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  if_id_hazard_stage #(.NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .PC_i(PC_i), .instr_i(instr_i),
    .branch_taken_i(branch_taken_i), .EX_MemRead_i(EX_MemRead_i), .EX_RT_reg_i(EX_RT_reg_i),
    .PC_o(PC_o), .instr_o(instr_o), .valid_o(valid_o),
    .RS_reg_o(RS_reg_o), .RT_reg_o(RT_reg_o), .RD_reg_o(RD_reg_o),
    .pc_write_o(pc_write_o), .Data_ID_EX_Flush(Data_ID_EX_Flush),
    .Branch_ID_EX_Flush(Branch_ID_EX_Flush),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the IF/ID register should hold and how many events occurred
  logic [15:0] m_pc, m_instr;
  logic        m_valid;
  int          m_stall, m_flush;

  function automatic logic m_hz();
    logic [15:0] w;
    w = m_instr;
    return m_valid && EX_MemRead_i && (EX_RT_reg_i != 0) &&
           (EX_RT_reg_i == w[12:10] || EX_RT_reg_i == w[9:7]);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_valid = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input logic [15:0] pc, input logic [15:0] ins,
                       input logic br, input logic mr, input logic [2:0] rt);
    @(negedge clk_i);
    PC_i = pc; instr_i = ins; branch_taken_i = br; EX_MemRead_i = mr; EX_RT_reg_i = rt;
    #1;
  endtask

  task automatic tick();
    logic hz_now, br_now;
    logic [15:0] pc_now, ins_now;
    hz_now = m_hz(); br_now = branch_taken_i; pc_now = PC_i; ins_now = instr_i;
    @(posedge clk_i);
    if (br_now) begin
      m_pc = pc_now; m_instr = NOP; m_valid = 1'b0;
      m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
    end else if (hz_now) begin
      m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    end else begin
      m_pc = pc_now; m_instr = ins_now; m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    branch_taken_i = 1'b1;
    #2;
    model_reset();
    checks++; if ({PC_o, instr_o, valid_o} !== {16'h0000, NOP, 1'b0}) begin
      errors++; $display("FAIL reset_regs: got %h/%h/%b expected 0000/%h/0", PC_o, instr_o, valid_o, NOP);
    end
    checks++; if ({stall_cnt_o, flush_cnt_o} !== '0) begin
      errors++; $display("FAIL reset_cnts: got %h/%h expected 0/0", stall_cnt_o, flush_cnt_o);
    end
    checks++; if ({pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush} !== 3'b101) begin
      errors++; $display("FAIL reset_comb_br: got %b expected 101", {pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush});
    end
    branch_taken_i = 1'b0;
    #1;
    checks++; if (Branch_ID_EX_Flush !== 1'b0) begin
      errors++; $display("FAIL reset_bflush_follow: got %b expected 0", Branch_ID_EX_Flush);
    end
    @(negedge clk_i) rst_n = 1'b1;
    // load a real instruction, then assert reset mid-cycle with no clock edge
    drive(16'h0002, 16'h1234, 1'b0, 1'b0, 3'd0);
    tick();
    checks++; if (valid_o !== 1'b1 || PC_o !== 16'h0002) begin
      errors++; $display("FAIL first_fetch: got valid=%b pc=%h expected 1/0002", valid_o, PC_o);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if ({PC_o, instr_o, valid_o, stall_cnt_o, flush_cnt_o} !== {16'h0000, NOP, 1'b0, {(2*CW){1'b0}}}) begin
      errors++; $display("FAIL async_reset: got pc=%h instr=%h valid=%b cnt=%h/%h expected all reset", PC_o, instr_o, valid_o, stall_cnt_o, flush_cnt_o);
    end
    @(negedge clk_i) rst_n = 1'b1;
  endtask

  task automatic test_straight_line();
    logic [15:0] ins;
    for (int i = 1; i <= 3; i++) begin
      ins = 16'($urandom);
      drive(16'(2 * i), ins, 1'b0, 1'b0, 3'($urandom));
      checks++; if ({pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush} !== 3'b100) begin
        errors++; $display("FAIL straight_comb[%0d]: got %b expected 100", i, {pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush});
      end
      tick();
      checks++; if ({PC_o, instr_o, valid_o, stall_cnt_o} !== {16'(2 * i), ins, 1'b1, 4'h0}) begin
        errors++; $display("FAIL straight_regs[%0d]: got pc=%h instr=%h v=%b st=%h expected %h/%h/1/0", i, PC_o, instr_o, valid_o, stall_cnt_o, 16'(2 * i), ins);
      end
    end
  endtask

  task automatic test_load_use();
    logic [15:0] dep, nxt;
    dep = {3'b000, 3'd3, 3'd5, 3'd2, 4'h1};
    nxt = 16'hA5A0;
    drive(16'h0010, dep, 1'b0, 1'b0, 3'd0);
    tick();
    checks++; if ({RS_reg_o, RT_reg_o, RD_reg_o} !== {3'd3, 3'd5, 3'd2}) begin
      errors++; $display("FAIL reg_fields: got %0d/%0d/%0d expected 3/5/2", RS_reg_o, RT_reg_o, RD_reg_o);
    end
    drive(16'h0012, nxt, 1'b0, 1'b1, 3'd3);
    checks++; if ({pc_write_o, Data_ID_EX_Flush} !== 2'b01) begin
      errors++; $display("FAIL loaduse_rs_comb: got pcw=%b dflush=%b expected 0/1", pc_write_o, Data_ID_EX_Flush);
    end
    tick();
    checks++; if ({PC_o, instr_o, stall_cnt_o} !== {16'h0010, dep, 4'h1}) begin
      errors++; $display("FAIL loaduse_hold: got pc=%h instr=%h st=%h expected 0010/%h/1", PC_o, instr_o, stall_cnt_o, dep);
    end
    drive(16'h0012, nxt, 1'b0, 1'b0, 3'd3);
    checks++; if ({pc_write_o, Data_ID_EX_Flush} !== 2'b10) begin
      errors++; $display("FAIL loaduse_resume: got pcw=%b dflush=%b expected 1/0", pc_write_o, Data_ID_EX_Flush);
    end
    tick();
    checks++; if (PC_o !== 16'h0012 || stall_cnt_o !== 4'h1) begin
      errors++; $display("FAIL loaduse_after: got pc=%h st=%h expected 0012/1", PC_o, stall_cnt_o);
    end
    // rt field dependency, then a load into r0 which must not stall
    drive(16'h0014, dep, 1'b0, 1'b0, 3'd0);
    tick();
    drive(16'h0016, nxt, 1'b0, 1'b1, 3'd5);
    checks++; if (pc_write_o !== 1'b0) begin
      errors++; $display("FAIL loaduse_rt: got pcw=%b expected 0", pc_write_o);
    end
    tick();
    drive(16'h0016, nxt, 1'b0, 1'b1, 3'd0);
    checks++; if ({pc_write_o, Data_ID_EX_Flush} !== 2'b10) begin
      errors++; $display("FAIL loaduse_r0: got pcw=%b dflush=%b expected 1/0", pc_write_o, Data_ID_EX_Flush);
    end
    tick();
    checks++; if (stall_cnt_o !== 4'h2 || PC_o !== 16'h0016) begin
      errors++; $display("FAIL loaduse_r0_regs: got st=%h pc=%h expected 2/0016", stall_cnt_o, PC_o);
    end
  endtask

  task automatic test_branch();
    drive(16'h0040, 16'hBEEF, 1'b1, 1'b0, 3'd0);
    checks++; if ({pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush} !== 3'b101) begin
      errors++; $display("FAIL branch_comb: got %b expected 101", {pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush});
    end
    tick();
    checks++; if ({PC_o, instr_o, valid_o, flush_cnt_o} !== {16'h0040, NOP, 1'b0, 4'h1}) begin
      errors++; $display("FAIL branch_regs: got pc=%h instr=%h v=%b fl=%h expected 0040/%h/0/1", PC_o, instr_o, valid_o, flush_cnt_o, NOP);
    end
  endtask

  task automatic test_simultaneous();
    int st_before;
    drive(16'h0050, {3'b010, 3'd4, 3'd1, 3'd0, 4'h0}, 1'b0, 1'b0, 3'd0);
    tick();
    st_before = m_stall;
    drive(16'h0060, 16'h7777, 1'b1, 1'b1, 3'd4);
    checks++; if ({pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush} !== 3'b101) begin
      errors++; $display("FAIL simul_comb: got %b expected 101", {pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush});
    end
    tick();
    checks++; if ({32'(stall_cnt_o), valid_o, PC_o} !== {32'(st_before), 1'b0, 16'h0060}) begin
      errors++; $display("FAIL simul_regs: got st=%0d v=%b pc=%h expected %0d/0/0060", stall_cnt_o, valid_o, PC_o, st_before);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(16'h0070, {3'b000, 3'd6, 3'd2, 3'd1, 4'h0}, 1'b0, 1'b0, 3'd0);
    tick();
    drive(16'h0072, 16'h1111, 1'b0, 1'b1, 3'd6);
    checks++; if (Data_ID_EX_Flush !== 1'b1) begin
      errors++; $display("FAIL midstall_pre: got dflush=%b expected 1", Data_ID_EX_Flush);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if ({pc_write_o, Data_ID_EX_Flush, valid_o, stall_cnt_o} !== {3'b100, 4'h0}) begin
      errors++; $display("FAIL midstall_reset: got pcw=%b dflush=%b v=%b st=%h expected 1/0/0/0", pc_write_o, Data_ID_EX_Flush, valid_o, stall_cnt_o);
    end
    @(negedge clk_i) begin rst_n = 1'b1; EX_MemRead_i = 1'b0; end
  endtask

  task automatic test_random();
    logic [15:0] ins, w;
    logic [2:0] rt;
    for (int i = 0; i < 400; i++) begin
      w = m_instr;
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rt = w[12:10];
        1: rt = w[9:7];
        default: rt = 3'($urandom);
      endcase
      drive(16'($urandom), ins, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, rt);
      checks++; if ({pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush} !==
                    {branch_taken_i || !m_hz(), !branch_taken_i && m_hz(), branch_taken_i}) begin
        errors++; $display("FAIL rand_comb[%0d]: got %b expected %b", i, {pc_write_o, Data_ID_EX_Flush, Branch_ID_EX_Flush},
                           {branch_taken_i || !m_hz(), !branch_taken_i && m_hz(), branch_taken_i});
      end
      tick();
      checks++; if ({PC_o, instr_o, valid_o, 32'(stall_cnt_o), 32'(flush_cnt_o)} !==
                    {m_pc, m_instr, m_valid, 32'(m_stall), 32'(m_flush)}) begin
        errors++; $display("FAIL rand_regs[%0d]: got pc=%h instr=%h v=%b st=%0d fl=%0d expected %h/%h/%b/%0d/%0d",
                           i, PC_o, instr_o, valid_o, stall_cnt_o, flush_cnt_o, m_pc, m_instr, m_valid, m_stall, m_flush);
      end
    end
  endtask

  task automatic test_saturation();
    drive(16'h0080, {3'b000, 3'd3, 3'd1, 3'd1, 4'h0}, 1'b0, 1'b0, 3'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(16'h0082, 16'h2222, 1'b0, 1'b1, 3'd3);
      tick();
    end
    checks++; if (stall_cnt_o !== 4'hF || m_stall != CMAX) begin
      errors++; $display("FAIL stall_saturate: got %h expected F", stall_cnt_o);
    end
    for (int i = 0; i < 20; i++) begin
      drive(16'(i), 16'h3333, 1'b1, 1'b0, 3'd0);
      tick();
    end
    checks++; if (flush_cnt_o !== 4'hF || m_flush != CMAX) begin
      errors++; $display("FAIL flush_saturate: got %h expected F", flush_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_load_use();
    test_branch();
    test_simultaneous();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_stage.md
# if_id_hazard_stage

IF/ID pipeline register with integrated load-use hazard detection and branch squash control for the 16-bit pipelined core. Sits between instruction fetch and decode: captures the fetched PC and instruction, and drives the PC-write enable and the `Data_ID_EX_Flush` / `Branch_ID_EX_Flush` inputs of the downstream ID/EX stage. Keeps saturating stall and flush event counters for performance debug.

## Interface
- `NOP_INSTR`, default 16'h0000, instruction word loaded on reset and squash.
- `CNT_W`, default 16, width of the event counters.

- `clk_i`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `PC_i`  in  16  PC (PC+2) of fetched instruction
- `instr_i`  in  16  fetched instruction
- `branch_taken_i`  in  1  branch/jump resolved taken in EX, current cycle
- `EX_MemRead_i`  in  1  MemRead bit of the instruction now in ID/EX (ID/EX `MEM` bit 1)
- `EX_RT_reg_i`  in  3  destination (rt) of the instruction now in ID/EX
- `PC_o`  out  16  registered PC
- `instr_o`  out  16  registered instruction
- `valid_o`  out  1  registered instruction is real (not bubble)
- `RS_reg_o`, `RT_reg_o`, `RD_reg_o`  out  3 each  `instr_o[12:10]`, `[9:7]`, `[6:4]`
- `pc_write_o`  out  1  PC register load enable
- `Data_ID_EX_Flush`  out  1  insert bubble into ID/EX (load-use)
- `Branch_ID_EX_Flush`  out  1  squash ID/EX (taken branch)
- `stall_cnt_o`  out  CNT_W  load-use stall cycles, saturating
- `flush_cnt_o`  out  CNT_W  branch squash events, saturating

## Operation
- Instruction format: opcode `[15:13]`, rs `[12:10]`, rt `[9:7]`, rd `[6:4]`, func `[3:0]`. r0 is hard-wired zero.
- Hazard (combinational): `hz = valid_o & EX_MemRead_i & (EX_RT_reg_i != 0) & (EX_RT_reg_i == RS_reg_o | EX_RT_reg_i == RT_reg_o)`.
- Mode per cycle, priority highest first:
  - SQUASH (`branch_taken_i`): next `instr_o = NOP_INSTR`, `valid_o = 0`, `PC_o = PC_i`; `pc_write_o = 1`; `Branch_ID_EX_Flush = 1`; `Data_ID_EX_Flush = 0`; `flush_cnt_o` +1.
  - STALL (`hz` and no branch): IF/ID holds all fields; `pc_write_o = 0`; `Data_ID_EX_Flush = 1`; `stall_cnt_o` +1.
  - RUN: load `PC_i`, `instr_i`, `valid_o = 1`; `pc_write_o = 1`; both flushes 0.
- FSM state register `{RESET_BUBBLE, RUN, STALLED}`: reset -> RESET_BUBBLE; RESET_BUBBLE -> RUN unconditionally on first edge after reset release (first fetch loaded, no hazard possible since `valid_o = 0`); RUN -> STALLED when STALL taken; STALLED -> RUN on next edge (bubble now in ID/EX clears `hz`); any state -> RUN on SQUASH. In STALLED, if `hz` re-asserts (new load in ID/EX), stall again; state stays STALLED.
- Counters saturate at all-ones; no wrap.
- `Branch_ID_EX_Flush` equals `branch_taken_i` regardless of state, including RESET_BUBBLE.

## Timing
- Reset (asynchronous, immediate): `PC_o = 0`, `instr_o = NOP_INSTR`, `valid_o = 0`, counters 0, state RESET_BUBBLE; with registers at reset, `pc_write_o = 1`, `Data_ID_EX_Flush = 0`, `Branch_ID_EX_Flush = branch_taken_i`.
- IF/ID latency: 1 cycle, `PC_i`/`instr_i` at edge N visible on outputs after edge N.
- `pc_write_o`, both flush outputs: combinational in the same cycle as the triggering condition; consumed by PC and ID/EX on the next edge.
- Load-use penalty: exactly 1 stall cycle per dependent load.
- Reset asserted mid-stall or mid-squash: all state returns to reset values immediately; no pending stall survives.

## Test plan
- Reset: assert `rst_n = 0` mid-cycle with `valid_o = 1` -> outputs go to `PC_o = 0`, `instr_o = 16'h0000`, `valid_o = 0`, counters 0 without a clock edge.
- Straight-line: feed PCs 2,4,6 with non-load ID/EX -> `PC_o` follows one cycle later, `pc_write_o = 1`, both flushes 0, `stall_cnt_o = 0`.
- Load-use: `instr_o` rs = 3, `EX_MemRead_i = 1`, `EX_RT_reg_i = 3` -> `pc_write_o = 0`, `Data_ID_EX_Flush = 1` for 1 cycle, IF/ID held, `stall_cnt_o = 1`; next cycle with `EX_MemRead_i = 0` resumes. Repeat with `EX_RT_reg_i = 0` -> no stall.
- Branch: `branch_taken_i = 1` with `PC_i = 16'h0040` -> next `instr_o = NOP`, `valid_o = 0`, `PC_o = 16'h0040`, `Branch_ID_EX_Flush = 1`, `flush_cnt_o = 1`.
- Simultaneous: `hz` and `branch_taken_i` same cycle -> squash wins: `pc_write_o = 1`, `Data_ID_EX_Flush = 0`, `stall_cnt_o` unchanged.
- Saturation: with `CNT_W = 4`, force 20 stalls -> `stall_cnt_o` holds 4'hF.
